// File: rtl/seri_pkg.sv
// Shared types and constants for the serial frame link.
package seri_pkg;

    typedef enum logic [2:0] {BOSTA, BASLA, VERI, DUR, BEKLE} alici_durum_t;

    localparam logic IDLE_SEVIYE  = 1'b1;
    localparam int   N_VARSAYILAN = 5;

endpackage

// File: rtl/seri_alici_if.sv
// Serial line plus the receiver's word/strobe outputs.
interface seri_alici_if #(parameter int N = seri_pkg::N_VARSAYILAN);

    logic         rx;
    logic [N-1:0] veri;
    logic         gecerli;
    logic         hata;
    logic         mesgul;

    modport master (output rx, input veri, gecerli, hata, mesgul);
    modport slave  (input rx, output veri, gecerli, hata, mesgul);

endinterface

// File: rtl/seri_alici_bit_zamanlayici.sv
// Bit-period timer: after a clear, pulses at +P/2 and then every P cycles.
module bit_zamanlayici #(
    parameter int P = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic temizle,
    output logic ornekle
);

    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] SON   = CW'(P - 1);
    // The counter reads 0 in the cycle after the clear edge, so the match is one behind.
    localparam logic [CW-1:0] HEDEF = CW'((P / 2 + P - 1) % P);

    logic [CW-1:0] sayac;

    always_ff @(posedge clk) begin
        if (reset || temizle) begin
            sayac <= '0;
        end else if (sayac == SON) begin
            sayac <= '0;
        end else begin
            sayac <= sayac + CW'(1);
        end
    end

    assign ornekle = (sayac == HEDEF);

endmodule

// File: rtl/seri_alici.sv
// Serial frame receiver: start bit, N data bits LSB first, stop bit; mid-bit sampling.
module seri_alici
    import seri_pkg::*;
#(
    parameter int N = N_VARSAYILAN,
    parameter int P = 1
) (
    input logic clk,
    input logic reset,
    seri_alici_if.slave bus
);

    localparam int BW = $clog2(N + 1);
    // With P=1 the start-bit check falls on the detection edge itself.
    localparam bit HEMEN = ((P / 2) == 0);

    alici_durum_t  durum;
    logic [BW-1:0] bit_idx;
    logic [N-1:0]  kaydirma;
    logic          ornekle;
    logic          temizle;

    assign temizle = (durum == BOSTA) && (bus.rx != IDLE_SEVIYE);

    bit_zamanlayici #(.P(P)) u_zamanlayici (
        .clk     (clk),
        .reset   (reset),
        .temizle (temizle),
        .ornekle (ornekle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            durum       <= BOSTA;
            bit_idx     <= '0;
            kaydirma    <= '0;
            bus.veri    <= '0;
            bus.gecerli <= 1'b0;
            bus.hata    <= 1'b0;
            bus.mesgul  <= 1'b0;
        end else begin
            bus.gecerli <= 1'b0;
            bus.hata    <= 1'b0;
            case (durum)
                BOSTA: begin
                    if (bus.rx != IDLE_SEVIYE) begin
                        durum      <= HEMEN ? VERI : BASLA;
                        bit_idx    <= '0;
                        bus.mesgul <= 1'b1;
                    end
                end
                BASLA: begin
                    if (ornekle) begin
                        if (bus.rx == IDLE_SEVIYE) begin
                            durum      <= BOSTA;
                            bus.mesgul <= 1'b0;
                        end else begin
                            durum   <= VERI;
                            bit_idx <= '0;
                        end
                    end
                end
                VERI: begin
                    if (ornekle) begin
                        // Shifting in from the top leaves the first bit at bit 0 after N samples.
                        kaydirma <= {bus.rx, kaydirma[N-1:1]};
                        bit_idx  <= bit_idx + BW'(1);
                        if (bit_idx == BW'(N - 1)) begin
                            durum <= DUR;
                        end
                    end
                end
                DUR: begin
                    if (ornekle) begin
                        if (bus.rx == IDLE_SEVIYE) begin
                            bus.veri    <= kaydirma;
                            bus.gecerli <= 1'b1;
                            bus.mesgul  <= 1'b0;
                            durum       <= BOSTA;
                        end else begin
                            bus.hata <= 1'b1;
                            durum    <= BEKLE;
                        end
                    end
                end
                BEKLE: begin
                    if (bus.rx == IDLE_SEVIYE) begin
                        durum      <= BOSTA;
                        bus.mesgul <= 1'b0;
                    end
                end
                default: begin
                    durum      <= BOSTA;
                    bus.mesgul <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seri_alici.md
# seri_alici

Serial receiver for the 5-bit frame line driven by the upstream sequencer: idle-high, one low start bit, N data bits LSB first, one high stop bit. Runs on the same clock as the transmitter. Samples each bit at mid-period, reassembles the word and presents it with a one-cycle valid strobe. Reports framing errors and resynchronises on an idle line. Sits directly downstream of the sequencer's `y` output; its `veri`/`gecerli` feed the consuming register stage.

## Interface
- `N`, default 5: data bits per frame.
- `P`, default 1: clock cycles per bit (≥1). `P=1` is the direct same-clock link to the sequencer.
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high; one clock, one reset, no other clock domains.
- `rx`  in  1  serial line (sequencer `y`); idle = 1.
- `veri`  out  N  last correctly framed word, bit 0 = first data bit received; holds until the next good frame.
- `gecerli`  out  1  one-cycle strobe: `veri` updated this cycle.
- `hata`  out  1  one-cycle strobe: stop bit sampled low.
- `mesgul`  out  1  frame in progress.

## Operation
- States: BOSTA, BASLA, VERI, DUR, BEKLE.
- BOSTA: `mesgul`=0. Edge with `rx`=0 → BASLA, cycle counter cleared. This edge is E0.
- BASLA: at E0 + P/2 (integer division; for P=1 the check is E0 itself), `rx`=1 → BOSTA (false start, no strobe). `rx`=0 → VERI, bit index 0.
- VERI: every P cycles, sample `rx` into shift register at bit index i. Bit i is sampled at E0 + P/2 + (i+1)·P. After bit N-1 → DUR.
- DUR: sample at E0 + P/2 + (N+1)·P.
  - `rx`=1: `veri` ← shift register, `gecerli`=1 next cycle, → BOSTA.
  - `rx`=0: `hata`=1 next cycle, `veri` unchanged, → BEKLE.
- BEKLE: stay until an edge sees `rx`=1 → BOSTA. A low line never starts a frame from BEKLE.
- `mesgul`=1 in BASLA, VERI, DUR and BEKLE.
- Counters:
  - Cycle counter is `$clog2(P)` bits, minimum 1, and wraps at P-1.
  - Bit index is `$clog2(N+1)` bits.
  - No arithmetic overflow is possible.
- `gecerli` and `hata` are never high together.

## Timing
- Reset values: `veri`=0, `gecerli`=0, `hata`=0, `mesgul`=0; state BOSTA; counters 0.
- `reset` overrides everything at the next edge, including mid-frame. A partial frame is discarded with no strobe and `veri` is cleared.
- With P=1, frame latency from the start-bit edge E0 to `gecerli` high is N+2 cycles: 7 for N=5.
- Back-to-back frames: after a good stop, the receiver is in BOSTA. A start bit on the very next edge is accepted.
- The sequencer always inserts at least one idle cycle between frames, so there is no overlap.
- A stretched start bit from the sequencer (holding `baslat` high) is outside the frame format: the receiver decodes the extra low cycles as data 0 bits. This is the required behaviour, not an error to mask.
- All outputs are registered. No combinational path from `rx` to any output.

## Structure
- Package `seri_pkg`: `typedef enum logic [2:0] {BOSTA, BASLA, VERI, DUR, BEKLE} alici_durum_t;` plus `IDLE_SEVIYE`=1'b1 and `N_VARSAYILAN`=5. The sequencer's state type also moves into this package.
- One sub-module is natural: `bit_zamanlayici`, the P-cycle counter.
  - Output: a one-cycle `ornekle` (sample) pulse.
  - Behaviour: restarts on a `temizle` (clear) pulse, and places the first pulse at +P/2.
  - Everything else lives in `seri_alici`.

## Test plan
- P=1, `rx` driven by a sequencer instance with `d`=5'b10110, single-cycle `baslat` → `gecerli` high for exactly 1 cycle, 7 cycles after E0. `veri`=5'b10110, `hata`=0.
- P=1, hand-driven frame 0,1,1,1,1,1 then `rx`=0 at the stop slot → `hata` pulse. `veri` keeps its previous value 5'b10110. `mesgul` stays high until `rx` returns to 1, then BOSTA.
- P=4, a 1-cycle low glitch on an idle line → no strobe, `mesgul` drops within 2 cycles. A following legal frame of 5'b01001 is received correctly.
- P=1, `reset` asserted during data bit 2 of a frame → all outputs 0 next cycle, no strobe. The next full frame 5'b11111 is received.
- P=1, two frames 5'b00001 then 5'b10000 with the minimum one idle cycle between → two `gecerli` pulses 8 cycles apart, with the correct words.
